netfpga_sume_10g_tx_store_fwd: RTL
==================================

// Module: netfpga_sume_10g_tx_store_fwd
// PURPOSE
//  Store-and-forward frame buffer in front of the 10GbE MAC TX AXI-Stream input.
//  The MAC underruns and corrupts a frame if tvalid drops mid-frame, so this block
//  releases a frame only once its tlast word is stored, then streams it gap-free.
//  Frames that do not fit in the buffer are dropped whole and counted.
// PARAMETERS
//  DEPTH       512  buffer depth in 64-bit words; power of two, >= 4
//  DROP_CNT_W  32   width of the dropped-frame counter
// PORTS
//  clk156            in   1   156.25 MHz core clock (MAC coreclk domain)
//  reset             in   1   synchronous, active-high
//  s_axis_tdata      in   64  upstream frame data
//  s_axis_tkeep      in   8   byte enables, contiguous from bit 0
//  s_axis_tvalid     in   1   upstream valid
//  s_axis_tlast      in   1   last word of frame
//  s_axis_tready     out  1   upstream ready
//  m_axis_tdata      out  64  to MAC s_axis_tx_tdata
//  m_axis_tkeep      out  8   to MAC s_axis_tx_tkeep
//  m_axis_tvalid     out  1   to MAC s_axis_tx_tvalid
//  m_axis_tlast      out  1   to MAC s_axis_tx_tlast
//  m_axis_tready     in   1   from MAC s_axis_tx_tready
//  frames_stored     out  ADDR_W+1  complete frames in the buffer; ADDR_W=log2(DEPTH)
//  drop_cnt          out  DROP_CNT_W  frames dropped, saturating
// BEHAVIOUR
//  Reset: all outputs 0; pointers, frame count and FSMs cleared; partial frames lost.
//  s_axis_tready = 1 in every cycle outside reset. No upstream backpressure.
//  Storage: 73-bit words {tlast, tkeep, tdata}. Pointers wr_ptr, wr_commit, rd_ptr
//   are ADDR_W+1 bits and wrap modulo 2*DEPTH. used = wr_ptr - rd_ptr; full = used==DEPTH.
//  Write FSM:
//   PASS: each accepted word is written at wr_ptr, and wr_ptr is incremented. Accepted
//    tlast: wr_commit <= wr_ptr+1 and frames_stored increments.
//   PASS with an accepted word while full: the word is not written, and wr_ptr <= wr_commit
//    (rewind). drop_cnt increments. If that word has tlast, stay in PASS; otherwise go to DROP.
//   DROP: discard accepted words. Accepted tlast -> PASS. No further drop_cnt increment.
//  Read side: only committed words are read (rd_ptr never passes wr_commit).
//   Read FSM IDLE -> SEND when frames_stored > 0. In SEND, words are read in order and
//   m_axis_tlast follows the stored bit. An m_axis handshake with tlast -> frames_stored
//   decrements, then SEND if frames_stored still > 0 after the update, else IDLE.
//   Back-to-back frames need no idle cycle.
//  Gap-free rule: from the first word to tlast of a frame, m_axis_tvalid stays 1
//   continuously. The RAM has 1-cycle read latency, so a prefetch/skid register keeps the
//   output stage full. m_tdata/tkeep/tlast stay stable while tvalid=1 and tready=0.
//  Latency: with tlast accepted at edge N and the buffer otherwise empty, m_axis_tvalid=1
//   in cycle N+2. Cut-through is not permitted.
//  Simultaneous commit and tlast send in one cycle: frames_stored unchanged.
//   Simultaneous write and read: both take effect. Free space is measured against rd_ptr,
//   so drained words are immediately reusable.
//  A frame longer than DEPTH words is always dropped and causes no deadlock.
//  drop_cnt saturates at all-ones.
//  Reset mid-frame on either side: buffer flushes. The MAC sees tvalid=0 from the next cycle.
// TESTING
//  1. Single 8-word frame, tkeep last = 8'h0F, m_tready=1 -> m_tvalid at N+2; 8 contiguous
//     beats with identical data/keep; tlast on beat 8; frames_stored 1 -> 0.
//  2. s_tvalid toggling 1/0 within a 6-word frame -> output is 6 beats, tvalid never
//     deasserted mid-frame, and nothing is emitted before the input tlast.
//  3. DEPTH=16, frame of 20 words after a stored 4-word frame -> 20-word frame dropped,
//     drop_cnt=1; the 4-word frame is output intact; the next 3-word frame passes.
//  4. Four back-to-back 2-word frames with m_tready=1 -> 8 consecutive output beats,
//     no idle cycle; m_tready random 50% -> data stable while stalled.
//  5. Reset asserted on the 3rd output beat of a 10-word frame -> all outputs 0 next cycle;
//     a new 5-word frame after reset is output intact.
//  6. drop_cnt preloaded near max (DROP_CNT_W=2), 5 oversize frames -> drop_cnt holds 2'b11.

Source files
------------

// File: rtl/netfpga_sume_10g_tx_store_fwd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : netfpga_sume_10g_tx_store_fwd
// Purpose  : Store-and-forward frame buffer ahead of the 10GbE MAC TX stream.
//            A frame is released to the MAC only after its tlast word has been
//            stored, then streamed with tvalid held high from first word to
//            tlast. Frames that do not fit are dropped whole and counted.
// Ports    : clk156 / reset          core clock, synchronous active-high reset
//            s_axis_*                upstream stream (never backpressured)
//            m_axis_*                stream to the MAC TX interface
//            frames_stored           complete frames currently buffered
//            drop_cnt                saturating count of dropped frames
// Revision : 1.0  initial release
// ============================================================================
module netfpga_sume_10g_tx_store_fwd #(
    parameter int DEPTH      = 512,
    parameter int DROP_CNT_W = 32
) (
    input  logic                     clk156,
    input  logic                     reset,
    input  logic [63:0]              s_axis_tdata,
    input  logic [7:0]               s_axis_tkeep,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic [63:0]              m_axis_tdata,
    output logic [7:0]               m_axis_tkeep,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic [$clog2(DEPTH):0]   frames_stored,
    output logic [DROP_CNT_W-1:0]    drop_cnt
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_PTR_W  = c_ADDR_W + 1;
    localparam int c_WORD_W = 73;

    localparam logic [c_PTR_W-1:0]    c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_PTR_W-1:0]    c_PTR_DEPTH = c_PTR_W'(DEPTH);
    localparam logic [DROP_CNT_W-1:0] c_DROP_ONE  = DROP_CNT_W'(1);

    typedef enum logic [0:0] {
        WR_PASS = 1'b0,
        WR_DROP = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_SEND = 1'b1
    } rd_state_t;

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    logic [c_WORD_W-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_wr_commit;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W-1:0]    r_frames_stored;
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic                  r_s_ready;
    logic [c_WORD_W-1:0]   r_out;
    logic                  r_out_vld;
    wr_state_t             r_wr_state;
    wr_state_t             w_wr_state_nxt;
    rd_state_t             r_rd_state;
    rd_state_t             w_rd_state_nxt;

    logic [c_PTR_W-1:0]    w_used;
    logic                  w_full;
    logic                  w_accept;
    logic                  w_wr_en;
    logic                  w_commit;
    logic                  w_drop;
    logic                  w_rewind;
    logic                  w_pop_last;
    logic                  w_rd_en;
    logic [c_PTR_W-1:0]    w_frames_nxt;

    // Free space is measured against the RAM read pointer: a word already
    // moved into the output register no longer occupies its RAM slot.
    assign w_used     = r_wr_ptr - r_rd_ptr;
    assign w_full     = (w_used == c_PTR_DEPTH);
    assign w_accept   = s_axis_tvalid & r_s_ready;
    assign w_pop_last = r_out_vld & m_axis_tready & r_out[c_WORD_W-1];

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk156) begin
        if (reset) begin
            r_wr_state <= WR_PASS;
        end else begin
            r_wr_state <= w_wr_state_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_en        = 1'b0;
        w_commit       = 1'b0;
        w_drop         = 1'b0;
        w_rewind       = 1'b0;
        case (r_wr_state)
            WR_PASS: begin
                if (w_accept) begin
                    if (w_full) begin
                        // Frame cannot fit: discard what was written of it.
                        w_drop   = 1'b1;
                        w_rewind = 1'b1;
                        if (!s_axis_tlast) begin
                            w_wr_state_nxt = WR_DROP;
                        end
                    end else begin
                        w_wr_en  = 1'b1;
                        w_commit = s_axis_tlast;
                    end
                end
            end
            WR_DROP: begin
                if (w_accept && s_axis_tlast) begin
                    w_wr_state_nxt = WR_PASS;
                end
            end
            default: w_wr_state_nxt = WR_PASS;
        endcase
    end

    always_ff @(posedge clk156) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    // ------------------------------------------------------------------
    // Pointers, counters, upstream ready
    // ------------------------------------------------------------------
    always_comb begin
        w_frames_nxt = r_frames_stored;
        case ({w_commit, w_pop_last})
            2'b10:   w_frames_nxt = r_frames_stored + c_PTR_ONE;
            2'b01:   w_frames_nxt = r_frames_stored - c_PTR_ONE;
            default: w_frames_nxt = r_frames_stored;
        endcase
    end

    always_ff @(posedge clk156) begin
        if (reset) begin
            r_wr_ptr        <= '0;
            r_wr_commit     <= '0;
            r_rd_ptr        <= '0;
            r_frames_stored <= '0;
            r_drop_cnt      <= '0;
            r_s_ready       <= 1'b0;
        end else begin
            r_s_ready       <= 1'b1;
            r_frames_stored <= w_frames_nxt;
            if (w_rewind) begin
                r_wr_ptr <= r_wr_commit;
            end else if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_commit) begin
                r_wr_commit <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + c_DROP_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk156) begin
        if (reset) begin
            r_rd_state <= RD_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            RD_IDLE: begin
                if (r_frames_stored != '0) begin
                    w_rd_state_nxt = RD_SEND;
                end
            end
            RD_SEND: begin
                if (w_pop_last) begin
                    w_rd_state_nxt = (w_frames_nxt != '0) ? RD_SEND : RD_IDLE;
                end
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    // The RAM read register doubles as the output stage. It is reloaded in
    // the same cycle the MAC takes the current word, so a committed frame
    // streams without bubbles. Only committed words are ever fetched, which
    // is what makes the stream gap-free once the first word is shown.
    assign w_rd_en = (r_rd_ptr != r_wr_commit)
                   & (~r_out_vld | m_axis_tready)
                   & ((r_rd_state == RD_SEND) | (r_frames_stored != '0));

    always_ff @(posedge clk156) begin
        if (reset) begin
            r_out     <= '0;
            r_out_vld <= 1'b0;
        end else if (w_rd_en) begin
            r_out     <= r_mem[r_rd_ptr[c_ADDR_W-1:0]];
            r_out_vld <= 1'b1;
        end else if (m_axis_tready) begin
            r_out_vld <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axis_tready = r_s_ready;
    assign m_axis_tdata  = r_out[63:0];
    assign m_axis_tkeep  = r_out[71:64];
    assign m_axis_tlast  = r_out[72];
    assign m_axis_tvalid = r_out_vld;
    assign frames_stored = r_frames_stored;
    assign drop_cnt      = r_drop_cnt;

endmodule
`default_nettype wire
